// File: rtl/switch_bounce_generator.sv
// Bouncing mechanical contact emulator.
// Each change of target_level produces the new level on bounce_out, then
// 2*n toggles (n glitches back to the old level and recoveries), spaced by
// a gap drawn from a 16-bit Galois LFSR. The sequence always ends on the
// latched target level.
module switch_bounce_generator #(
    parameter int          MAX_BOUNCES   = 15,
    parameter int          MIN_INTERVAL  = 4,
    parameter int          INTERVAL_BITS = 6,
    parameter int          RANDOMIZE     = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic        INITIAL_LEVEL = 1'b0,
    localparam int         NB_W  = $clog2(MAX_BOUNCES + 1),
    localparam int         CNT_W = $clog2(2 * MAX_BOUNCES + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             target_level,
    input  logic [NB_W-1:0]  num_bounces,
    output logic             bounce_out,
    output logic             busy,
    output logic             settled,
    output logic [CNT_W-1:0] bounce_count
);

    // Width of the "toggles still to emit" counter (holds 2*MAX_BOUNCES).
    localparam int REM_W  = $clog2(2 * MAX_BOUNCES + 1);
    // Width of the gap timer; it holds gap-1, largest gap is MIN + 2^BITS - 1.
    localparam int TMR_W  = $clog2(MIN_INTERVAL + (1 << INTERVAL_BITS));
    // Largest value the num_bounces port can carry.
    localparam int NB_MAX = (1 << NB_W) - 1;

    typedef enum logic {
        ST_IDLE,
        ST_BOUNCE
    } state_t;

    state_t             state_q;
    logic               bounce_q;
    logic               busy_q;
    logic               settled_q;
    logic [CNT_W-1:0]   count_q;
    logic [REM_W-1:0]   remaining_q;
    logic [TMR_W-1:0]   timer_q;
    logic [15:0]        lfsr_q;

    logic [15:0]        lfsr_d;
    logic [TMR_W-1:0]   reload_d;
    logic [NB_W-1:0]    n_clamped;

    // Galois LFSR step, polynomial x^16+x^14+x^13+x^11+1 (shift right).
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Timer reload value (gap-1) taken from the LFSR as it stands this cycle.
    if (RANDOMIZE != 0) begin : g_rand_gap
        assign reload_d = TMR_W'(MIN_INTERVAL - 1) + TMR_W'(lfsr_q[INTERVAL_BITS-1:0]);
    end else begin : g_fixed_gap
        assign reload_d = TMR_W'(MIN_INTERVAL - 1);
    end

    // Clamp the requested glitch count; only needed when the port can exceed it.
    if (NB_MAX > MAX_BOUNCES) begin : g_clamp
        assign n_clamped = (num_bounces > NB_W'(MAX_BOUNCES)) ? NB_W'(MAX_BOUNCES)
                                                              : num_bounces;
    end else begin : g_no_clamp
        assign n_clamped = num_bounces;
    end

    // Sequence FSM: start on a level mismatch, then toggle every gap cycles.
    // NOTE: every register here uses <= so all of them update together from
    // the pre-edge values; a blocking = would leak new values into later lines.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bounce_q    <= INITIAL_LEVEL;
            busy_q      <= 1'b0;
            settled_q   <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            lfsr_q    <= lfsr_d;
            settled_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (target_level != bounce_q) begin
                        bounce_q <= target_level;
                        count_q  <= CNT_W'(1);
                        if (n_clamped == '0) begin
                            settled_q <= 1'b1;
                        end else begin
                            remaining_q <= REM_W'({n_clamped, 1'b0});
                            timer_q     <= reload_d;
                            busy_q      <= 1'b1;
                            state_q     <= ST_BOUNCE;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (timer_q == '0) begin
                        bounce_q    <= ~bounce_q;
                        count_q     <= count_q + CNT_W'(1);
                        remaining_q <= remaining_q - REM_W'(1);
                        timer_q     <= reload_d;
                        if (remaining_q == REM_W'(1)) begin
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            settled_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bounce_out   = bounce_q;
    assign busy         = busy_q;
    assign settled      = settled_q;
    assign bounce_count = count_q;

endmodule

// File: tb/tb_switch_bounce_generator.sv
// Bench for switch_bounce_generator: two instances share stimulus, one with
// default parameters (random gaps, 15 glitches max) and one with fixed
// 4-cycle gaps and a 10-glitch clamp. A reference model turns each accepted
// transition into a list of expected output events; a monitor compares them.
module tb_switch_bounce_generator;

    localparam int          MIN_INT = 4;
    localparam int          IBITS   = 6;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic             clk = 1'b0;
    logic             reset;
    logic             target;
    logic [3:0]       nb;
    logic [1:0]       bo, bz, st;
    logic [1:0][4:0]  bc;

    always #5 clk = ~clk;

    switch_bounce_generator u_rnd (
        .clock(clk), .reset(reset), .target_level(target), .num_bounces(nb),
        .bounce_out(bo[0]), .busy(bz[0]), .settled(st[0]), .bounce_count(bc[0])
    );

    switch_bounce_generator #(
        .MAX_BOUNCES(10), .RANDOMIZE(0)
    ) u_fix (
        .clock(clk), .reset(reset), .target_level(target), .num_bounces(nb),
        .bounce_out(bo[1]), .busy(bz[1]), .settled(st[1]), .bounce_count(bc[1])
    );

    typedef struct {
        int cyc;
        bit lvl;
        int cnt;
        bit busy;
        bit settled;
    } evt_t;

    evt_t        exp_q[2][$];
    int          stamp = 0;
    int          m_end[2];
    bit          m_level[2];
    bit          exp_busy[2];
    bit          rst_seen = 1'b1;
    logic [15:0] m_lfsr;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input int d, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, stamp, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int gap_of(input int d, input logic [15:0] l);
        if (d == 0) return MIN_INT + int'(l & 16'((1 << IBITS) - 1));
        return MIN_INT;
    endfunction

    // Expand one accepted transition into its full list of expected edges.
    task automatic start_seq(input int d);
        int          mx, n, t, cnt, le, g;
        bit          lv;
        logic [15:0] lf;
        mx  = (d == 0) ? 15 : 10;
        n   = (int'(nb) > mx) ? mx : int'(nb);
        t   = stamp;
        lv  = target;
        cnt = 1;
        lf  = m_lfsr;
        le  = stamp;
        exp_q[d].push_back('{t, lv, cnt, n > 0, n == 0});
        for (int i = 1; i <= 2 * n; i++) begin
            g = gap_of(d, lf);
            t = t + g;
            while (le < t) begin
                lf = lfsr_step(lf);
                le++;
            end
            lv  = ~lv;
            cnt = cnt + 1;
            exp_q[d].push_back('{t, lv, cnt, i < 2 * n, i == 2 * n});
        end
        m_end[d]   = t;
        m_level[d] = lv;
    endtask

    // Reference model: evaluated on every rising edge from the inputs alone.
    initial begin
        m_end[0] = -1; m_end[1] = -1;
        m_level[0] = 1'b0; m_level[1] = 1'b0;
        m_lfsr = SEED;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int d = 0; d < 2; d++) begin
                    exp_q[d].delete();
                    m_end[d]   = -1;
                    m_level[d] = 1'b0;
                end
                m_lfsr   = SEED;
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                for (int d = 0; d < 2; d++)
                    if (stamp > m_end[d] && target != m_level[d]) start_seq(d);
                m_lfsr = lfsr_step(m_lfsr);
            end
            for (int d = 0; d < 2; d++) exp_busy[d] = (stamp < m_end[d]);
            stamp++;
        end
    end

    // Monitor: on every falling edge, pop an expected event whenever the DUT
    // shows an edge or a settled pulse, and compare all observable fields.
    initial begin
        bit   prev[2];
        int   s;
        evt_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            s = stamp - 1;
            for (int d = 0; d < 2; d++) begin
                if (rst_seen) begin
                    check("rst_level", d, 32'(bo[d]), 0);
                    check("rst_busy", d, 32'(bz[d]), 0);
                    check("rst_settled", d, 32'(st[d]), 0);
                    check("rst_count", d, 32'(bc[d]), 0);
                end else begin
                    while (exp_q[d].size() > 0 && exp_q[d][0].cyc < s) begin
                        check("missed_edge_cycle", d, 32'(s), 32'(exp_q[d][0].cyc));
                        void'(exp_q[d].pop_front());
                    end
                    if (bo[d] != prev[d] || st[d]) begin
                        check("edge_expected", d, 32'(exp_q[d].size() > 0), 1);
                        if (exp_q[d].size() > 0) begin
                            e = exp_q[d].pop_front();
                            check("edge_cycle", d, 32'(s), 32'(e.cyc));
                            check("edge_level", d, 32'(bo[d]), 32'(e.lvl));
                            check("edge_count", d, 32'(bc[d]), 32'(e.cnt));
                            check("edge_settled", d, 32'(st[d]), 32'(e.settled));
                            check("edge_busy", d, 32'(bz[d]), 32'(e.busy));
                        end
                    end
                    check("busy", d, 32'(bz[d]), 32'(exp_busy[d]));
                end
                prev[d] = bo[d];
            end
        end
    end

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((stamp <= m_end[0] + 1 || stamp <= m_end[1] + 1) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("idle_within_budget", 0, 32'(c < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    // Stimulus: directed cases first, then randomized transitions and resets.
    initial begin
        reset  = 1'b1;
        target = 1'b0;
        nb     = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Zero glitches: single edge with an immediate settled pulse.
        nb = 4'd0; target = 1'b1;
        repeat (5) @(negedge clk);

        // Two glitches, target flips back while busy.
        nb = 4'd2; target = 1'b0;
        repeat (6) @(negedge clk);
        target = 1'b1;
        wait_idle(4000);

        // Maximum request: 31 edges on u_rnd, clamped to 21 edges on u_fix.
        nb = 4'd15; target = 1'b0;
        wait_idle(4000);

        // Reset in the middle of a three-glitch sequence.
        nb = 4'd3; target = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        target = 1'b0;
        repeat (3) @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            nb     = 4'($urandom_range(0, 15));
            target = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 300)) @(negedge clk);
        end
        wait_idle(4000);

        for (int d = 0; d < 2; d++) check("queue_drained", d, 32'(exp_q[d].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
